// File: rtl/security_decoder.sv
// security_decoder: buffers one frame of XOR-encrypted ciphertext words, then
// emits them in reverse arrival order (undoing the encoder's LIFO stage) after
// XOR-ing each with the shared key. Fill and drain phases never overlap.
module security_decoder #(
  parameter int                 WIDTH = 32,
  parameter int                 DEPTH = 16,
  parameter logic [WIDTH-1:0]   KEY   = 32'hAAAAAAAA
) (
  input  logic             clk,
  input  logic             rst_n,      // active-high asynchronous reset
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  input  logic             in_last,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  output logic             out_last,
  input  logic             out_ready,
  output logic             busy,
  output logic             ovf_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  localparam logic [0:0] S_FILL  = 1'b0;
  localparam logic [0:0] S_DRAIN = 1'b1;

  logic [0:0]       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic [WIDTH-1:0] mem_q [DEPTH];

  logic             accept_s;
  logic             pop_s;
  logic [AW-1:0]    wr_idx_s;
  logic [AW-1:0]    rd_idx_s;

  // Handshakes and addressing derived directly from the phase register.
  // In DRAIN cnt is 1..DEPTH, so the low bits minus one wrap to the top slot
  // correctly when cnt equals DEPTH.
  assign in_ready  = (state_q == S_FILL);
  assign out_valid = (state_q == S_DRAIN);
  assign accept_s  = in_valid & in_ready;
  assign pop_s     = out_valid & out_ready;
  assign wr_idx_s  = cnt_q[AW-1:0];
  assign rd_idx_s  = cnt_q[AW-1:0] - AW'(1);
  assign busy      = (cnt_q != CW'(0)) || (state_q == S_DRAIN);
  assign ovf_err   = ovf_q;

  // Plaintext output: top-of-stack word XOR key, zero whenever not valid.
  always_comb begin
    out_data = '0;
    out_last = 1'b0;
    if (out_valid) begin
      out_data = mem_q[rd_idx_s] ^ KEY;
      out_last = (cnt_q == CW'(1));
    end else begin
      out_data = '0;
      out_last = 1'b0;
    end
  end

  // Next-state logic for the fill/drain phase, word count and overflow pulse.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ovf_d   = 1'b0;
    case (state_q)
      S_FILL: begin
        if (accept_s) begin
          cnt_d = cnt_q + CW'(1);
          if (in_last) begin
            state_d = S_DRAIN;
          end else if (cnt_q == CW'(DEPTH - 1)) begin
            // Frame filled the buffer without a terminator: drain what we
            // have and let the remaining words start a fresh frame.
            state_d = S_DRAIN;
            ovf_d   = 1'b1;
          end else begin
            state_d = S_FILL;
          end
        end else begin
          state_d = S_FILL;
        end
      end
      S_DRAIN: begin
        if (pop_s) begin
          cnt_d = cnt_q - CW'(1);
          if (cnt_q == CW'(1)) begin
            state_d = S_FILL;
          end else begin
            state_d = S_DRAIN;
          end
        end else begin
          state_d = S_DRAIN;
        end
      end
      default: begin
        state_d = S_FILL;
        cnt_d   = '0;
      end
    endcase
  end

  // Control registers; reset discards any frame in progress immediately.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state_q <= S_FILL;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
    end
  end

  // Frame storage; contents need no reset because cnt gates every read.
  always_ff @(posedge clk) begin
    if (accept_s) begin
      mem_q[wr_idx_s] <= in_data;
    end
  end

endmodule
